// File: rtl/line_engine_if.sv
// Bundles the CPU-facing MMIO port, the frame-buffer pixel-write port and the busy flag.
// Latency: none, wiring only.
// Backpressure: px_ready from the arbiter stalls the pixel stream; the MMIO side has none.
interface line_engine_if;
    logic        mmio_we;
    logic        mmio_re;
    logic [3:0]  mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        px_valid;
    logic        px_ready;
    logic [31:0] px_addr;
    logic [31:0] px_data;
    logic        busy;

    // Engine view: responder on MMIO, requester on the pixel port.
    modport slave (
        input  mmio_we, mmio_re, mmio_addr, mmio_wdata, px_ready,
        output mmio_rdata, px_valid, px_addr, px_data, busy
    );

    // Environment view: CPU decode plus frame-buffer arbiter.
    modport master (
        output mmio_we, mmio_re, mmio_addr, mmio_wdata, px_ready,
        input  mmio_rdata, px_valid, px_addr, px_data, busy
    );
endinterface

// File: rtl/line_engine.sv
// Line-drawing accelerator: MMIO register file plus integer Bresenham rasteriser.
// Latency: first pixel request two cycles after the START write, then one pixel per cycle.
// Backpressure: the pixel is held stable while px_ready is low; START while busy is dropped.
module line_engine #(
    parameter int COORD_W     = 10,
    parameter int STRIDE_LOG2 = 10
) (
    input  logic         clk,
    input  logic         rst,
    line_engine_if.slave bus
);
    localparam int EW = COORD_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;
    state_t state_q, state_d;

    // Shadow registers written by firmware at any time.
    logic [31:0]          base_sh_q, color_sh_q;
    logic [COORD_W-1:0]   x0_sh_q, y0_sh_q, x1_sh_q, y1_sh_q;
    // Working copies the rasteriser actually uses.
    logic [31:0]          base_q, color_q;
    logic [COORD_W-1:0]   x0_q, y0_q, x1_q, y1_q;
    logic [COORD_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic signed [EW-1:0] dx_q, dy_q, err_q, err_d;
    logic                 sx_neg_q, sy_neg_q;
    logic                 done_q;
    logic [31:0]          rdata_q, rdata_d;

    logic                 start_req, status_rd, px_fire, at_end, busy_w;
    logic signed [EW-1:0] x0_s, y0_s, x1_s, y1_s, dx_set, dy_set, e2;
    logic                 step_x, step_y;

    assign start_req = bus.mmio_we && (bus.mmio_addr == 4'd6);
    assign status_rd = bus.mmio_re && (bus.mmio_addr == 4'd7);
    assign busy_w    = (state_q != S_IDLE);
    assign px_fire   = (state_q == S_DRAW) && bus.px_ready;
    assign at_end    = (cur_x_q == x1_q) && (cur_y_q == y1_q);

    // Coordinates widened to signed so the deltas cannot wrap.
    assign x0_s   = $signed({3'b000, x0_q});
    assign y0_s   = $signed({3'b000, y0_q});
    assign x1_s   = $signed({3'b000, x1_q});
    assign y1_s   = $signed({3'b000, y1_q});
    assign dx_set = (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
    assign dy_set = (y1_s >= y0_s) ? (y0_s - y1_s) : (y1_s - y0_s);

    assign bus.px_valid   = (state_q == S_DRAW);
    assign bus.px_addr    = base_q + (32'(cur_y_q) << (STRIDE_LOG2 + 2)) + (32'(cur_x_q) << 2);
    assign bus.px_data    = color_q;
    assign bus.busy       = busy_w;
    assign bus.mmio_rdata = rdata_q;

    // Next state: IDLE -> SETUP -> DRAW (until endpoint accepted) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_req) state_d = S_SETUP;
            S_SETUP: state_d = S_DRAW;
            S_DRAW:  if (px_fire && at_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One Bresenham step; both axis updates use the same e2 and pre-step err.
    always_comb begin
        e2      = err_q <<< 1;
        step_x  = (e2 >= dy_q);
        step_y  = (e2 <= dx_q);
        err_d   = err_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (step_x) begin
            err_d   = err_d + dy_q;
            cur_x_d = sx_neg_q ? (cur_x_q - COORD_W'(1)) : (cur_x_q + COORD_W'(1));
        end
        if (step_y) begin
            err_d   = err_d + dx_q;
            cur_y_d = sy_neg_q ? (cur_y_q - COORD_W'(1)) : (cur_y_q + COORD_W'(1));
        end
    end

    // Read mux: shadows, status, zero for unmapped offsets.
    always_comb begin
        rdata_d = 32'd0;
        case (bus.mmio_addr)
            4'd0:    rdata_d = base_sh_q;
            4'd1:    rdata_d = color_sh_q;
            4'd2:    rdata_d = 32'(x0_sh_q);
            4'd3:    rdata_d = 32'(y0_sh_q);
            4'd4:    rdata_d = 32'(x1_sh_q);
            4'd5:    rdata_d = 32'(y1_sh_q);
            4'd7:    rdata_d = {30'd0, done_q, busy_w};
            default: rdata_d = 32'd0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Shadow register writes, accepted in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_sh_q  <= '0;
            color_sh_q <= '0;
            x0_sh_q    <= '0;
            y0_sh_q    <= '0;
            x1_sh_q    <= '0;
            y1_sh_q    <= '0;
        end else if (bus.mmio_we) begin
            case (bus.mmio_addr)
                4'd0:    base_sh_q  <= bus.mmio_wdata;
                4'd1:    color_sh_q <= bus.mmio_wdata;
                4'd2:    x0_sh_q    <= bus.mmio_wdata[COORD_W-1:0];
                4'd3:    y0_sh_q    <= bus.mmio_wdata[COORD_W-1:0];
                4'd4:    x1_sh_q    <= bus.mmio_wdata[COORD_W-1:0];
                4'd5:    y1_sh_q    <= bus.mmio_wdata[COORD_W-1:0];
                default: ;
            endcase
        end
    end

    // Working registers: latch on START, initialise in SETUP, step on each accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            color_q  <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_req) begin
                    base_q  <= base_sh_q;
                    color_q <= color_sh_q;
                    x0_q    <= x0_sh_q;
                    y0_q    <= y0_sh_q;
                    x1_q    <= x1_sh_q;
                    y1_q    <= y1_sh_q;
                end
                S_SETUP: begin
                    dx_q     <= dx_set;
                    dy_q     <= dy_set;
                    err_q    <= dx_set + dy_set;
                    sx_neg_q <= !(x0_q < x1_q);
                    sy_neg_q <= !(y0_q < y1_q);
                    cur_x_q  <= x0_q;
                    cur_y_q  <= y0_q;
                end
                S_DRAW: if (px_fire && !at_end) begin
                    err_q   <= err_d;
                    cur_x_q <= cur_x_d;
                    cur_y_q <= cur_y_d;
                end
                default: ;
            endcase
        end
    end

    // Sticky completion flag (set beats clear) and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == S_DONE)          done_q <= 1'b1;
            else if (start_req || status_rd) done_q <= 1'b0;
            if (bus.mmio_re) rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_line_engine.sv
`timescale 1ns/1ps
module tb_line_engine;
    localparam int ROW_BYTES = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_engine_if bus();
    line_engine #(.COORD_W(10), .STRIDE_LOG2(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    int stall_err = 0;
    int ready_mode = 0;
    int ph = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_addr[$];
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [31:0] prev_a = '0, prev_d = '0;

    // Pixel monitor: records accepted pixels and counts handshake-rule violations.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (prev_v && !prev_r) begin
                    if (!bus.px_valid || bus.px_addr !== prev_a || bus.px_data !== prev_d)
                        stall_err++;
                end
                if (bus.px_valid && bus.px_ready) begin
                    got_addr.push_back(bus.px_addr);
                    got_data.push_back(bus.px_data);
                end
                prev_v = bus.px_valid;
                prev_r = bus.px_ready;
                prev_a = bus.px_addr;
                prev_d = bus.px_data;
            end
        end
    end

    // Arbiter model: always ready, 1-0-0 pattern, or random.
    initial begin
        bus.px_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       begin bus.px_ready = (ph % 3 == 0); ph++; end
                2:       bus.px_ready = 1'($urandom_range(0, 1));
                default: bus.px_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mmio_write(input logic [3:0] a, input logic [31:0] d);
        bus.mmio_addr = a; bus.mmio_wdata = d; bus.mmio_we = 1'b1;
        tick();
        bus.mmio_we = 1'b0;
    endtask

    task automatic mmio_read(input logic [3:0] a, output logic [31:0] d);
        bus.mmio_addr = a; bus.mmio_re = 1'b1;
        tick();
        bus.mmio_re = 1'b0;
        d = bus.mmio_rdata;
    endtask

    task automatic program_line(input logic [31:0] base, input logic [31:0] color,
                                input int x0, input int y0, input int x1, input int y1);
        mmio_write(4'd0, base);
        mmio_write(4'd1, color);
        mmio_write(4'd2, 32'(x0));
        mmio_write(4'd3, 32'(y0));
        mmio_write(4'd4, 32'(x1));
        mmio_write(4'd5, 32'(y1));
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        int n = 0;
        while (bus.busy && n < budget) begin tick(); n++; end
        timed_out = bus.busy;
    endtask

    // Reference: textbook integer Bresenham over plain ints, producing byte addresses.
    task automatic build_expected(input int x0, input int y0, input int x1, input int y1,
                                  input logic [31:0] base);
        int x, y, dx, dy, sx, sy, err, e2;
        exp_addr.delete();
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        x = x0; y = y0; err = dx + dy;
        forever begin
            exp_addr.push_back(base + 32'(y * ROW_BYTES) + 32'(x * 4));
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        bus.mmio_we = 1'b0; bus.mmio_re = 1'b0; bus.mmio_addr = '0; bus.mmio_wdata = '0;
        rst = 1'b1;
        repeat (2) tick();
        n_vec++; if (bus.px_valid !== 1'b0) begin n_err++; $display("FAIL reset_px_valid: got %b want 0", bus.px_valid); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.mmio_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.mmio_rdata); end
        rst = 1'b0;
        tick();
        for (int a = 0; a < 8; a++) begin
            mmio_read(4'(a), rd);
            n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL reset_reg%0d: got %h want 0", a, rd); end
        end
    endtask

    task automatic test_horizontal();
        logic [31:0] rd;
        logic [31:0] want [4] = '{32'h10400000, 32'h10400004, 32'h10400008, 32'h1040000C};
        bit to;
        ready_mode = 0;
        program_line(32'h10400000, 32'h00FF00FF, 0, 0, 3, 0);
        got_addr.delete(); got_data.delete();
        mmio_write(4'd6, 32'd0);
        n_vec++; if (bus.px_valid !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL horiz_setup: got valid=%b busy=%b want 0/1", bus.px_valid, bus.busy); end
        tick();
        n_vec++; if (bus.px_valid !== 1'b1 || bus.px_addr !== 32'h10400000) begin n_err++; $display("FAIL horiz_latency: got valid=%b addr=%h want 1/10400000", bus.px_valid, bus.px_addr); end
        wait_idle(50, to);
        n_vec++; if (to) begin n_err++; $display("FAIL horiz_timeout: got busy want idle"); end
        n_vec++; if (got_addr.size() != 4) begin n_err++; $display("FAIL horiz_count: got %0d want 4", got_addr.size()); end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            n_vec++; if (got_addr[i] !== want[i] || got_data[i] !== 32'h00FF00FF) begin
                n_err++; $display("FAIL horiz_px%0d: got %h/%h want %h/00ff00ff", i, got_addr[i], got_data[i], want[i]);
            end
        end
        mmio_read(4'd7, rd);
        n_vec++; if (rd !== 32'h2) begin n_err++; $display("FAIL horiz_status: got %h want 2", rd); end
    endtask

    task automatic test_steep();
        int xs [6] = '{2, 2, 2, 1, 1, 1};
        int ys [6] = '{5, 4, 3, 2, 1, 0};
        logic [31:0] base = 32'h20000000;
        logic [31:0] want;
        bit to;
        ready_mode = 0;
        program_line(base, 32'hDEADBEEF, 2, 5, 1, 0);
        got_addr.delete(); got_data.delete();
        mmio_write(4'd6, 32'd0);
        wait_idle(50, to);
        n_vec++; if (to) begin n_err++; $display("FAIL steep_timeout: got busy want idle"); end
        n_vec++; if (got_addr.size() != 6) begin n_err++; $display("FAIL steep_count: got %0d want 6", got_addr.size()); end
        for (int i = 0; i < 6 && i < got_addr.size(); i++) begin
            want = base + 32'(ys[i] * 4096) + 32'(xs[i] * 4);
            n_vec++; if (got_addr[i] !== want || got_data[i] !== 32'hDEADBEEF) begin
                n_err++; $display("FAIL steep_px%0d: got %h/%h want %h/deadbeef", i, got_addr[i], got_data[i], want);
            end
        end
    endtask

    task automatic test_single();
        int cnt = 0;
        ready_mode = 0;
        program_line(32'h30000000, 32'h12345678, 7, 9, 7, 9);
        got_addr.delete(); got_data.delete();
        mmio_write(4'd6, 32'd0);
        while (bus.busy && cnt < 20) begin cnt++; tick(); end
        n_vec++; if (cnt != 3) begin n_err++; $display("FAIL single_busy_cycles: got %0d want 3", cnt); end
        n_vec++; if (got_addr.size() != 1) begin n_err++; $display("FAIL single_count: got %0d want 1", got_addr.size()); end
        else begin
            n_vec++; if (got_addr[0] !== 32'h3000901C) begin n_err++; $display("FAIL single_addr: got %h want 3000901c", got_addr[0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] base = 32'h40000000;
        logic [31:0] want;
        bit to;
        ph = 0; ready_mode = 1; stall_err = 0;
        program_line(base, 32'hCAFEF00D, 0, 0, 3, 3);
        got_addr.delete(); got_data.delete();
        mmio_write(4'd6, 32'd0);
        wait_idle(100, to);
        n_vec++; if (to) begin n_err++; $display("FAIL bp_timeout: got busy want idle"); end
        n_vec++; if (stall_err != 0) begin n_err++; $display("FAIL bp_stable: got %0d violations want 0", stall_err); end
        n_vec++; if (got_addr.size() != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", got_addr.size()); end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            want = base + 32'(i * 4096) + 32'(i * 4);
            n_vec++; if (got_addr[i] !== want) begin n_err++; $display("FAIL bp_px%0d: got %h want %h", i, got_addr[i], want); end
        end
        ready_mode = 0;
    endtask

    task automatic test_busy();
        logic [31:0] rd;
        logic [31:0] base = 32'h50000000;
        bit to;
        ph = 0; ready_mode = 1;
        program_line(base, 32'h0000AAAA, 0, 0, 9, 0);
        got_addr.delete(); got_data.delete();
        mmio_write(4'd6, 32'd0);
        repeat (3) tick();
        mmio_read(4'd7, rd);
        n_vec++; if (rd !== 32'h1) begin n_err++; $display("FAIL busy_status_busy: got %h want 1", rd); end
        mmio_write(4'd4, 32'd100);
        mmio_write(4'd6, 32'd0);
        wait_idle(200, to);
        n_vec++; if (to) begin n_err++; $display("FAIL busy_timeout1: got busy want idle"); end
        build_expected(0, 0, 9, 0, base);
        n_vec++; if (got_addr.size() != exp_addr.size()) begin n_err++; $display("FAIL busy_count1: got %0d want %0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            n_vec++; if (got_addr[i] !== exp_addr[i]) begin n_err++; $display("FAIL busy_px%0d: got %h want %h", i, got_addr[i], exp_addr[i]); end
        end
        mmio_read(4'd7, rd);
        n_vec++; if (rd !== 32'h2) begin n_err++; $display("FAIL busy_status_done: got %h want 2", rd); end
        mmio_read(4'd7, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL busy_status_clear: got %h want 0", rd); end
        ready_mode = 0;
        got_addr.delete(); got_data.delete();
        mmio_write(4'd6, 32'd0);
        wait_idle(300, to);
        n_vec++; if (to) begin n_err++; $display("FAIL busy_timeout2: got busy want idle"); end
        n_vec++; if (got_addr.size() != 101) begin n_err++; $display("FAIL busy_count2: got %0d want 101", got_addr.size()); end
        else begin
            n_vec++; if (got_addr[100] !== base + 32'd400) begin n_err++; $display("FAIL busy_last2: got %h want %h", got_addr[100], base + 32'd400); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [31:0] base = 32'h60000000;
        int n = 0;
        ready_mode = 0;
        program_line(base, 32'h0BADF00D, 0, 0, 9, 0);
        got_addr.delete(); got_data.delete();
        mmio_write(4'd6, 32'd0);
        while (got_addr.size() < 2 && n < 50) begin tick(); n++; end
        n_vec++; if (bus.px_valid !== 1'b1 || bus.px_addr !== base + 32'd8) begin
            n_err++; $display("FAIL rstmid_third: got valid=%b addr=%h want 1/%h", bus.px_valid, bus.px_addr, base + 32'd8);
        end
        rst = 1'b1;
        #1;
        n_vec++; if (bus.px_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", bus.px_valid); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int a = 0; a < 6; a++) begin
            mmio_read(4'(a), rd);
            n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL rstmid_shadow%0d: got %h want 0", a, rd); end
        end
        repeat (20) tick();
        n_vec++; if (got_addr.size() != 2) begin n_err++; $display("FAIL rstmid_count: got %0d want 2", got_addr.size()); end
    endtask

    task automatic test_random();
        logic [31:0] base, color;
        int x0, y0, x1, y1, maxc, dxm, dym, npx;
        bit to;
        ready_mode = 2; stall_err = 0;
        for (int t = 0; t < 16; t++) begin
            maxc  = (t % 4 == 3) ? 511 : 63;
            base  = $urandom;
            color = $urandom;
            x0 = $urandom_range(0, maxc); y0 = $urandom_range(0, maxc);
            x1 = $urandom_range(0, maxc); y1 = $urandom_range(0, maxc);
            program_line(base, color, x0, y0, x1, y1);
            build_expected(x0, y0, x1, y1, base);
            dxm = (x1 > x0) ? x1 - x0 : x0 - x1;
            dym = (y1 > y0) ? y1 - y0 : y0 - y1;
            npx = ((dxm > dym) ? dxm : dym) + 1;
            got_addr.delete(); got_data.delete();
            mmio_write(4'd6, 32'd0);
            wait_idle(npx * 10 + 50, to);
            n_vec++; if (to) begin n_err++; $display("FAIL rand%0d_timeout: got busy want idle", t); end
            n_vec++; if (got_addr.size() != npx) begin n_err++; $display("FAIL rand%0d_count: got %0d want %0d", t, got_addr.size(), npx); end
            for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
                n_vec++; if (got_addr[i] !== exp_addr[i] || got_data[i] !== color) begin
                    n_err++; $display("FAIL rand%0d_px%0d: got %h/%h want %h/%h", t, i, got_addr[i], got_data[i], exp_addr[i], color);
                end
            end
        end
        n_vec++; if (stall_err != 0) begin n_err++; $display("FAIL rand_stable: got %0d violations want 0", stall_err); end
        ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep();
        test_single();
        test_backpressure();
        test_busy();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/line_engine.md
Name: line_engine

Overview:
- Memory-mapped line-drawing accelerator; the responder end of the CPU's graphics MMIO writes.
- Firmware writes the frame-buffer base, a color and two endpoints, then writes START.
- The engine rasterises the line with integer Bresenham and emits one pixel write per cycle to the frame-buffer write port, using a valid/ready handshake.
- It sits between the CPU MMIO decode and the frame-buffer memory arbiter.

Parameters:
- COORD_W, 10, width of the x/y coordinate fields (0..1023).
- STRIDE_LOG2, 10, log2 of pixels per frame-buffer row.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mmio_we  in  1  register write strobe, one cycle per write.
- mmio_re  in  1  register read strobe.
- mmio_addr  in  4  word offset: 0 FB_BASE, 1 COLOR, 2 X0, 3 Y0, 4 X1, 5 Y1, 6 START, 7 STATUS.
- mmio_wdata  in  32  write data.
- mmio_rdata  out  32  read data; valid the cycle after mmio_re.
- px_valid  out  1  pixel write request.
- px_ready  in  1  arbiter accepts the pixel this cycle.
- px_addr  out  32  byte address of the pixel.
- px_data  out  32  pixel color.
- busy  out  1  a line is being drawn.

Behaviour:
- Reset (async, active-high): all registers, FSM and outputs are 0; FSM enters IDLE.
- Register writes:
  - Writes to offsets 0-5 update shadow registers in any state.
  - X/Y registers take wdata[COORD_W-1:0]; COLOR and FB_BASE take all 32 bits.
  - Shadow writes never disturb a line in progress; the engine works on latched copies.
- START (offset 6, any wdata):
  - In IDLE: latch shadows into working registers, go to SETUP next cycle.
  - In any other state: ignored. No queuing, no error.
- Offsets 7-15 are write-ignored.
- STATUS read (offset 7): {30'b0, done_sticky, busy}.
  - done_sticky sets when a line completes.
  - It clears on START or on a STATUS read; if both happen in the same cycle, set wins.
- Other offsets read back their shadow value; unmapped offsets read 0.
- FSM states:
  - IDLE → SETUP on START.
  - SETUP (1 cycle):
    - dx = |x1-x0|, dy = -|y1-y0|.
    - sx = +1 if x0<x1 else -1; sy likewise from y0 vs y1.
    - err = dx+dy; cur = (x0,y0).
    - → DRAW.
  - DRAW:
    - Assert px_valid with px_addr = FB_BASE + (cur_y << (STRIDE_LOG2+2)) + (cur_x << 2), and px_data = COLOR.
    - On px_valid & px_ready: if cur == (x1,y1), go to DONE. Otherwise step as below.
    - Step: e2 = 2*err. If e2 >= dy, then err += dy and cur_x += sx. If e2 <= dx, then err += dx and cur_y += sy. Both updates use the same e2 and the same err.
  - DONE (1 cycle): set done_sticky → IDLE.
- Signed arithmetic: err and e2 are signed COORD_W+3 bits; no overflow is possible within the coordinate range.
- Handshake:
  - px_addr and px_data stay stable while px_valid=1 and px_ready=0.
  - px_valid never drops without a handshake, except on reset.
  - Sustained throughput is 1 pixel/cycle when px_ready=1.
- Pixel count: exactly max(dx,|dy|)+1 pixels, endpoints inclusive.
- Degenerate line: x0==x1 and y0==y1 emits exactly one pixel.
- Latency: first px_valid appears 2 cycles after the START write cycle (START → SETUP → DRAW).
- busy = 1 in SETUP, DRAW and DONE; 0 in IDLE.
- Reset mid-line: the line is abandoned immediately, px_valid=0, and no further pixels are emitted. Shadow registers are also cleared.

Test Plan:
- Horizontal line: FB_BASE=0x10400000, COLOR=0x00FF00FF, (0,0)→(3,0), px_ready=1.
  - Required: 4 pixels at 0x10400000, 0x10400004, 0x10400008, 0x1040000C, all with data 0x00FF00FF.
  - Required: first px_valid 2 cycles after START; done_sticky=1 afterwards.
- Steep reversed line: (2,5)→(1,0).
  - Required: exactly the sequence (2,5),(2,4),(2,3),(1,2),(1,1),(1,0).
  - Required: addresses equal base + y*4096 + x*4.
- Single point: (7,9)→(7,9).
  - Required: one pixel at base+0x9000+0x1C; busy high for 3 cycles.
- Backpressure: 45° line (0,0)→(3,3) with px_ready toggling 1,0,0,1,...
  - Required: px_addr/px_data held stable while stalled; 4 pixels in order (0,0),(1,1),(2,2),(3,3); no duplicates.
- Busy interactions: write X1=100 and issue START mid-line.
  - Required: current line is unchanged; the second START is ignored.
  - Required: the next START after IDLE uses X1=100.
  - Required: STATUS reads 0x1 while busy, 0x2 after completion, then 0x0 on the next read.
- Reset mid-draw: assert rst during the 3rd pixel of a 10-pixel line.
  - Required: px_valid drops asynchronously; busy=0; all shadows read 0; no pixel emitted after reset release.
